// File: rtl/dec_ctrl_if.sv
// Fetch-to-decode instruction channel. instr, instr_pc and illegal_insn are meaningful while
// instr_valid is high; an instruction transfers in every cycle where instr_valid && id_ready.
interface dec_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        illegal_insn;
    logic        id_ready;

    modport master (output instr_valid, instr, instr_pc, illegal_insn, input id_ready);
    modport slave  (input instr_valid, instr, instr_pc, illegal_insn, output id_ready);
endinterface

// File: rtl/dec_ctrl_fsm.sv
// Decode-stage sequencing controller: accepts instructions, handles SYSTEM opcodes, exceptions,
// interrupts, WFI sleep and debug entry/exit, and drives PC-redirect and CSR-save strobes.
module dec_ctrl_fsm #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0080,
    parameter logic [31:0] MTVEC_ADDR = 32'h0000_0100,
    parameter logic [31:0] DBG_ADDR   = 32'h1A11_0800
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    dec_ctrl_if.slave   fetch_if,
    input  logic        irq_i,
    input  logic        debug_req_i,
    input  logic [31:0] mepc_i,
    output logic        pc_set_o,
    output logic [31:0] pc_target_o,
    output logic        csr_save_o,
    output logic [31:0] csr_save_pc_o,
    output logic [5:0]  exc_cause_o,
    output logic        core_sleep_o,
    output logic        debug_mode_o,
    output logic [2:0]  state_o
);

    localparam logic [31:0] OP_ECALL  = 32'h0000_0073;
    localparam logic [31:0] OP_EBREAK = 32'h0010_0073;
    localparam logic [31:0] OP_MRET   = 32'h3020_0073;
    localparam logic [31:0] OP_DRET   = 32'h7B20_0073;
    localparam logic [31:0] OP_WFI    = 32'h1050_0073;

    localparam logic [5:0] CAUSE_ILLEGAL = 6'h02;
    localparam logic [5:0] CAUSE_BREAK   = 6'h03;
    localparam logic [5:0] CAUSE_ECALL   = 6'h0B;
    localparam logic [5:0] CAUSE_IRQ     = 6'h2B;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_BOOT_SET  = 3'd1,
        S_DECODE    = 3'd2,
        S_FLUSH     = 3'd3,
        S_SLEEP     = 3'd4,
        S_DBG_TAKEN = 3'd5
    } state_e;

    state_e      state_q;
    logic        pc_set_q;
    logic [31:0] pc_target_q;
    logic        csr_save_q;
    logic [31:0] csr_save_pc_q;
    logic [5:0]  exc_cause_q;
    logic        core_sleep_q;
    logic        debug_mode_q;
    logic [31:0] dpc_q;
    logic [31:0] dbg_pc_q;

    logic        take_dbg;
    logic        take_irq;
    logic        is_ebreak;
    logic        is_mret;
    logic        is_dret;
    logic        is_wfi;
    logic        exc_take_d;
    logic [5:0]  exc_cause_d;

    assign take_dbg  = debug_req_i && !debug_mode_q;
    assign take_irq  = irq_i && !debug_mode_q;
    assign is_ebreak = (fetch_if.instr == OP_EBREAK);
    assign is_mret   = (fetch_if.instr == OP_MRET);
    assign is_dret   = (fetch_if.instr == OP_DRET);
    assign is_wfi    = (fetch_if.instr == OP_WFI);

    // Anything that traps to MTVEC with a CSR save; the debug request outranks all of these.
    always_comb begin
        exc_take_d  = 1'b1;
        exc_cause_d = CAUSE_ILLEGAL;
        if (take_irq) begin
            exc_cause_d = CAUSE_IRQ;
        end else if (fetch_if.illegal_insn || (is_dret && !debug_mode_q)) begin
            exc_cause_d = CAUSE_ILLEGAL;
        end else if (fetch_if.instr == OP_ECALL) begin
            exc_cause_d = CAUSE_ECALL;
        end else if (is_ebreak && !debug_mode_q) begin
            exc_cause_d = CAUSE_BREAK;
        end else begin
            exc_take_d = 1'b0;
        end
    end

    assign fetch_if.id_ready = (state_q == S_DECODE) && fetch_if.instr_valid && !take_dbg && !take_irq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_RESET;
            pc_set_q      <= 1'b0;
            pc_target_q   <= '0;
            csr_save_q    <= 1'b0;
            csr_save_pc_q <= '0;
            exc_cause_q   <= '0;
            core_sleep_q  <= 1'b0;
            debug_mode_q  <= 1'b0;
            dpc_q         <= '0;
            dbg_pc_q      <= '0;
        end else begin
            pc_set_q   <= 1'b0;
            csr_save_q <= 1'b0;
            unique case (state_q)
                S_RESET: begin
                    state_q     <= S_BOOT_SET;
                    pc_set_q    <= 1'b1;
                    pc_target_q <= BOOT_ADDR;
                end
                S_BOOT_SET: state_q <= S_DECODE;
                S_DECODE: begin
                    if (fetch_if.instr_valid) begin
                        if (take_dbg) begin
                            state_q     <= S_DBG_TAKEN;
                            dbg_pc_q    <= fetch_if.instr_pc;
                            pc_set_q    <= 1'b1;
                            pc_target_q <= DBG_ADDR;
                        end else if (exc_take_d) begin
                            state_q       <= S_FLUSH;
                            pc_set_q      <= 1'b1;
                            pc_target_q   <= MTVEC_ADDR;
                            csr_save_q    <= 1'b1;
                            csr_save_pc_q <= fetch_if.instr_pc;
                            exc_cause_q   <= exc_cause_d;
                        end else if (is_ebreak) begin
                            state_q     <= S_FLUSH;
                            pc_set_q    <= 1'b1;
                            pc_target_q <= DBG_ADDR;
                        end else if (is_mret) begin
                            state_q     <= S_FLUSH;
                            pc_set_q    <= 1'b1;
                            pc_target_q <= mepc_i;
                        end else if (is_dret) begin
                            // Only reachable in debug mode; outside it DRET traps as illegal.
                            state_q      <= S_FLUSH;
                            pc_set_q     <= 1'b1;
                            pc_target_q  <= dpc_q;
                            debug_mode_q <= 1'b0;
                        end else if (is_wfi && !debug_mode_q) begin
                            state_q      <= S_SLEEP;
                            core_sleep_q <= 1'b1;
                        end
                    end
                end
                S_FLUSH: state_q <= S_DECODE;
                S_SLEEP: begin
                    if (irq_i || debug_req_i) begin
                        state_q      <= S_DECODE;
                        core_sleep_q <= 1'b0;
                    end
                end
                S_DBG_TAKEN: begin
                    state_q      <= S_DECODE;
                    dpc_q        <= dbg_pc_q;
                    debug_mode_q <= 1'b1;
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign pc_set_o      = pc_set_q;
    assign pc_target_o   = pc_target_q;
    assign csr_save_o    = csr_save_q;
    assign csr_save_pc_o = csr_save_pc_q;
    assign exc_cause_o   = exc_cause_q;
    assign core_sleep_o  = core_sleep_q;
    assign debug_mode_o  = debug_mode_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dec_ctrl_fsm.sv
// Bench for dec_ctrl_fsm: directed scenarios plus a randomized run against a cycle-level
// behavioural model of the controller's redirect/sleep/debug rules.
module tb_dec_ctrl_fsm;

    localparam logic [31:0] ITYPE  = 32'hE000_C113;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] DRET   = 32'h7B20_0073;
    localparam logic [31:0] WFI    = 32'h1050_0073;
    localparam logic [31:0] BOOT   = 32'h0000_0080;
    localparam logic [31:0] MTVEC  = 32'h0000_0100;
    localparam logic [31:0] DBGA   = 32'h1A11_0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq = 1'b0;
    logic        dreq = 1'b0;
    logic [31:0] mepc = '0;
    logic        pc_set;
    logic [31:0] pc_target;
    logic        csr_save;
    logic [31:0] save_pc;
    logic [5:0]  cause;
    logic        sleep;
    logic        dbg_mode;
    logic [2:0]  dut_state;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    dec_ctrl_if fetch_if();

    dec_ctrl_fsm dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_if      (fetch_if),
        .irq_i         (irq),
        .debug_req_i   (dreq),
        .mepc_i        (mepc),
        .pc_set_o      (pc_set),
        .pc_target_o   (pc_target),
        .csr_save_o    (csr_save),
        .csr_save_pc_o (save_pc),
        .exc_cause_o   (cause),
        .core_sleep_o  (sleep),
        .debug_mode_o  (dbg_mode),
        .state_o       (dut_state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic ill);
        fetch_if.instr_valid  = v;
        fetch_if.instr        = w;
        fetch_if.instr_pc     = pc;
        fetch_if.illegal_insn = ill;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0; irq = 1'b0; dreq = 1'b0; mepc = '0;
        drive(1'b0, '0, '0, 1'b0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; irq = 1'b0; dreq = 1'b0; mepc = '0;
        drive(1'b1, ITYPE, 32'h0, 1'b0);
        repeat (2) tick;
        checks++; if (pc_set !== 1'b0) $display("FAIL rst_pc_set got=%0h exp=0", pc_set); else passed++;
        checks++; if (pc_target !== 32'h0) $display("FAIL rst_target got=%0h exp=0", pc_target); else passed++;
        checks++; if (csr_save !== 1'b0) $display("FAIL rst_csr_save got=%0h exp=0", csr_save); else passed++;
        checks++; if (save_pc !== 32'h0) $display("FAIL rst_save_pc got=%0h exp=0", save_pc); else passed++;
        checks++; if (cause !== 6'h0) $display("FAIL rst_cause got=%0h exp=0", cause); else passed++;
        checks++; if (sleep !== 1'b0) $display("FAIL rst_sleep got=%0h exp=0", sleep); else passed++;
        checks++; if (dbg_mode !== 1'b0) $display("FAIL rst_dbg got=%0h exp=0", dbg_mode); else passed++;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL rst_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        rst_n = 1'b1;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL rel_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (pc_set !== 1'b1) $display("FAIL boot_pc_set got=%0h exp=1", pc_set); else passed++;
        checks++; if (pc_target !== BOOT) $display("FAIL boot_target got=%0h exp=%0h", pc_target, BOOT); else passed++;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL boot_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (pc_set !== 1'b0) $display("FAIL boot_done got=%0h exp=0", pc_set); else passed++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ITYPE, BOOT + 32'(4 * i), 1'b0);
            #2;
            checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL stream_ready[%0d] got=%0h exp=1", i, fetch_if.id_ready); else passed++;
            tick;
            checks++; if (pc_set !== 1'b0) $display("FAIL stream_pc_set[%0d] got=%0h exp=0", i, pc_set); else passed++;
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_ecall;
        reset_dut;
        drive(1'b1, ECALL, 32'h200, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL ecall_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b1, ITYPE, 32'h204, 1'b0);
        checks++; if (pc_set !== 1'b1) $display("FAIL ecall_pc_set got=%0h exp=1", pc_set); else passed++;
        checks++; if (pc_target !== MTVEC) $display("FAIL ecall_target got=%0h exp=%0h", pc_target, MTVEC); else passed++;
        checks++; if (csr_save !== 1'b1) $display("FAIL ecall_save got=%0h exp=1", csr_save); else passed++;
        checks++; if (save_pc !== 32'h200) $display("FAIL ecall_save_pc got=%0h exp=200", save_pc); else passed++;
        checks++; if (cause !== 6'h0B) $display("FAIL ecall_cause got=%0h exp=b", cause); else passed++;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL ecall_flush_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (pc_set !== 1'b0 || csr_save !== 1'b0) $display("FAIL ecall_strobe_len got=%0h%0h exp=00", pc_set, csr_save); else passed++;
        checks++; if (cause !== 6'h0B) $display("FAIL ecall_cause_hold got=%0h exp=b", cause); else passed++;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL ecall_next_accept got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_illegal_mret;
        reset_dut;
        drive(1'b1, 32'h0FFF_FFFF, 32'h220, 1'b1);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL ill_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (cause !== 6'h02) $display("FAIL ill_cause got=%0h exp=2", cause); else passed++;
        checks++; if (csr_save !== 1'b1 || save_pc !== 32'h220) $display("FAIL ill_save got=%0h/%0h exp=1/220", csr_save, save_pc); else passed++;
        tick;
        mepc = 32'h400;
        drive(1'b1, MRET, 32'h224, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL mret_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (pc_set !== 1'b1 || pc_target !== 32'h400) $display("FAIL mret_target got=%0h/%0h exp=1/400", pc_set, pc_target); else passed++;
        checks++; if (csr_save !== 1'b0) $display("FAIL mret_save got=%0h exp=0", csr_save); else passed++;
        checks++; if (cause !== 6'h02) $display("FAIL mret_cause_hold got=%0h exp=2", cause); else passed++;
        tick;
    endtask

    task automatic test_wfi_irq;
        reset_dut;
        drive(1'b1, WFI, 32'h240, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL wfi_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b1, ITYPE, 32'h244, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (sleep !== 1'b1) $display("FAIL wfi_sleep[%0d] got=%0h exp=1", i, sleep); else passed++;
            #2;
            checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL wfi_ready_low[%0d] got=%0h exp=0", i, fetch_if.id_ready); else passed++;
            tick;
        end
        irq = 1'b1;
        drive(1'b1, ITYPE, 32'h300, 1'b0);
        tick;
        checks++; if (sleep !== 1'b0 || pc_set !== 1'b0) $display("FAIL wake got=%0h/%0h exp=0/0", sleep, pc_set); else passed++;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL wake_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (pc_set !== 1'b1 || pc_target !== MTVEC) $display("FAIL irq_target got=%0h/%0h exp=1/100", pc_set, pc_target); else passed++;
        checks++; if (cause !== 6'h2B || save_pc !== 32'h300) $display("FAIL irq_cause got=%0h/%0h exp=2b/300", cause, save_pc); else passed++;
        irq = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        tick;
    endtask

    task automatic test_debug;
        reset_dut;
        irq = 1'b1; dreq = 1'b1;
        drive(1'b1, ITYPE, 32'h500, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL dbg_req_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        dreq = 1'b0;
        checks++; if (pc_set !== 1'b1 || pc_target !== DBGA) $display("FAIL dbg_target got=%0h/%0h exp=1/%0h", pc_set, pc_target, DBGA); else passed++;
        checks++; if (csr_save !== 1'b0) $display("FAIL dbg_save got=%0h exp=0", csr_save); else passed++;
        tick;
        checks++; if (dbg_mode !== 1'b1) $display("FAIL dbg_mode got=%0h exp=1", dbg_mode); else passed++;
        drive(1'b1, ITYPE, 32'h600, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL dbg_irq_ignored got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b1, DRET, 32'h604, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL dret_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (pc_set !== 1'b1 || pc_target !== 32'h500) $display("FAIL dret_target got=%0h/%0h exp=1/500", pc_set, pc_target); else passed++;
        checks++; if (dbg_mode !== 1'b0 || csr_save !== 1'b0) $display("FAIL dret_mode got=%0h/%0h exp=0/0", dbg_mode, csr_save); else passed++;
        drive(1'b1, ITYPE, 32'h508, 1'b0);
        tick;
        #2;
        checks++; if (fetch_if.id_ready !== 1'b0) $display("FAIL post_dret_ready got=%0h exp=0", fetch_if.id_ready); else passed++;
        tick;
        checks++; if (csr_save !== 1'b1 || cause !== 6'h2B || save_pc !== 32'h508) $display("FAIL post_dret_irq got=%0h/%0h/%0h exp=1/2b/508", csr_save, cause, save_pc); else passed++;
        irq = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        tick;
    endtask

    task automatic test_reset_mid;
        reset_dut;
        drive(1'b1, ECALL, 32'h700, 1'b0);
        tick;
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (pc_set !== 1'b0 || csr_save !== 1'b0) $display("FAIL flush_rst_strobe got=%0h/%0h exp=0/0", pc_set, csr_save); else passed++;
        checks++; if (pc_target !== 32'h0 || cause !== 6'h0 || save_pc !== 32'h0) $display("FAIL flush_rst_regs got=%0h/%0h/%0h exp=0/0/0", pc_target, cause, save_pc); else passed++;
        rst_n = 1'b1;
        tick;
        checks++; if (pc_set !== 1'b1 || pc_target !== BOOT) $display("FAIL reboot1 got=%0h/%0h exp=1/80", pc_set, pc_target); else passed++;
        tick;
        drive(1'b1, WFI, 32'h80, 1'b0);
        tick;
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (sleep !== 1'b1) $display("FAIL pre_rst_sleep got=%0h exp=1", sleep); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (sleep !== 1'b0 || fetch_if.id_ready !== 1'b0) $display("FAIL sleep_rst got=%0h/%0h exp=0/0", sleep, fetch_if.id_ready); else passed++;
        rst_n = 1'b1;
        tick;
        checks++; if (pc_set !== 1'b1 || pc_target !== BOOT) $display("FAIL reboot2 got=%0h/%0h exp=1/80", pc_set, pc_target); else passed++;
        tick;
    endtask

    task automatic test_dret_illegal;
        reset_dut;
        drive(1'b1, DRET, 32'h800, 1'b0);
        #2;
        checks++; if (fetch_if.id_ready !== 1'b1) $display("FAIL dret_ill_ready got=%0h exp=1", fetch_if.id_ready); else passed++;
        tick;
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (cause !== 6'h02 || csr_save !== 1'b1) $display("FAIL dret_ill_cause got=%0h/%0h exp=2/1", cause, csr_save); else passed++;
        checks++; if (pc_target !== MTVEC || save_pc !== 32'h800) $display("FAIL dret_ill_target got=%0h/%0h exp=100/800", pc_target, save_pc); else passed++;
        tick;
    endtask

    // Behavioural model state for the randomized run.
    logic        m_dbg, m_sleep, m_redir, m_enter_dbg, m_save;
    logic [31:0] m_dpc, m_dbg_pc, m_save_pc;
    logic [5:0]  m_cause;

    task automatic model_trap(input logic [5:0] c, input logic [31:0] pc);
        m_redir = 1'b1; m_save = 1'b1; m_save_pc = pc; m_cause = c;
        exp_q.push_back(MTVEC);
    endtask

    task automatic model_jump(input logic [31:0] t);
        m_redir = 1'b1;
        exp_q.push_back(t);
    endtask

    task automatic test_random;
        logic        v, ill, exp_ready;
        logic [31:0] w, pc, got_t;
        int          k;
        reset_dut;
        m_dbg = 0; m_sleep = 0; m_redir = 0; m_enter_dbg = 0; m_save = 0;
        m_dpc = '0; m_dbg_pc = '0; m_save_pc = '0; m_cause = '0;
        exp_q.delete();
        pc = 32'h1000;
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 15);
            ill = 1'b0;
            w = $urandom;
            w[6:0] = 7'h13;
            case (k)
                0: w = ECALL;
                1: w = EBREAK;
                2: w = MRET;
                3: w = DRET;
                4: w = WFI;
                5: ill = 1'b1;
                default: ;
            endcase
            irq  = ($urandom_range(0, 9) == 0);
            dreq = ($urandom_range(0, 19) == 0);
            mepc = {$urandom_range(0, 65535), 16'h0};
            pc = pc + 32'd4;
            drive(v, w, pc, ill);
            // Model one cycle: what the DUT must show now and in the next cycle.
            exp_ready = 1'b0;
            m_save = 1'b0;
            if (m_redir) begin
                m_redir = 1'b0;
                if (m_enter_dbg) begin m_dbg = 1'b1; m_dpc = m_dbg_pc; m_enter_dbg = 1'b0; end
            end else if (m_sleep) begin
                if (irq || dreq) m_sleep = 1'b0;
            end else if (v) begin
                if (dreq && !m_dbg) begin
                    model_jump(DBGA); m_enter_dbg = 1'b1; m_dbg_pc = pc;
                end else if (irq && !m_dbg) begin
                    model_trap(6'h2B, pc);
                end else begin
                    exp_ready = 1'b1;
                    if (ill || (w == DRET && !m_dbg)) model_trap(6'h02, pc);
                    else if (w == ECALL) model_trap(6'h0B, pc);
                    else if (w == EBREAK && !m_dbg) model_trap(6'h03, pc);
                    else if (w == EBREAK) model_jump(DBGA);
                    else if (w == MRET) model_jump(mepc);
                    else if (w == DRET) begin model_jump(m_dpc); m_dbg = 1'b0; end
                    else if (w == WFI && !m_dbg) m_sleep = 1'b1;
                end
            end
            #2;
            checks++; if (fetch_if.id_ready !== exp_ready) $display("FAIL rnd_ready[%0d] got=%0h exp=%0h", n, fetch_if.id_ready, exp_ready); else passed++;
            tick;
            checks++; if (pc_set !== m_redir) $display("FAIL rnd_pc_set[%0d] got=%0h exp=%0h", n, pc_set, m_redir); else passed++;
            if (pc_set === 1'b1 && exp_q.size() > 0) begin
                got_t = exp_q.pop_front();
                checks++; if (pc_target !== got_t) $display("FAIL rnd_target[%0d] got=%0h exp=%0h", n, pc_target, got_t); else passed++;
            end
            checks++; if (csr_save !== m_save) $display("FAIL rnd_save[%0d] got=%0h exp=%0h", n, csr_save, m_save); else passed++;
            checks++; if (save_pc !== m_save_pc || cause !== m_cause) $display("FAIL rnd_csr[%0d] got=%0h/%0h exp=%0h/%0h", n, save_pc, cause, m_save_pc, m_cause); else passed++;
            checks++; if (sleep !== m_sleep || dbg_mode !== m_dbg) $display("FAIL rnd_mode[%0d] got=%0h/%0h exp=%0h/%0h", n, sleep, dbg_mode, m_sleep, m_dbg); else passed++;
        end
        irq = 1'b0; dreq = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        checks++; if (exp_q.size() != 0) $display("FAIL rnd_redirects_left got=%0d exp=0", exp_q.size()); else passed++;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0);
        test_reset;
        test_ecall;
        test_illegal_mret;
        test_wfi_irq;
        test_debug;
        test_reset_mid;
        test_dret_illegal;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
